// File: rtl/mux_select_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mux_select_ctrl_pkg
// Shared types for the mux select sequencer: the controller state encoding
// and a small helper that classifies states.
// -----------------------------------------------------------------------------
package mux_select_ctrl_pkg;

    // Controller states; encodings are fixed so debug probes can decode them.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_QUIET   = 2'd1,
        ST_ACTIVE       = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    // True for the states that spend time waiting on a quiet bus and are
    // therefore bounded by the wait timeout.
    function automatic logic is_wait_state(input state_e st);
        return (st == ST_WAIT_QUIET) || (st == ST_RELEASE_WAIT);
    endfunction

    // True whenever a command is in flight.
    function automatic logic is_busy_state(input state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage : mux_select_ctrl_pkg

// File: rtl/mux_select_ctrl_quiet_detector.sv
// -----------------------------------------------------------------------------
// mux_select_ctrl_quiet_detector
// Watches the masked bus lines for activity. Keeps a one-cycle history of the
// bus and counts consecutive cycles in which no masked line changed.
//
// Ports:
//   sys_clk   in   system clock
//   n_reset   in   synchronous active-low reset
//   bus_line  in   WIDTH  observed bus, already synchronised
//   mask      in   WIDTH  lines whose activity matters
//   clear     in   restart the quiet count (state entry in the controller)
//   quiet_ok  out  the quiet count reaches QUIET_CYCLES at the coming edge
// -----------------------------------------------------------------------------
module mux_select_ctrl_quiet_detector #(
    parameter int WIDTH        = 4,
    parameter int QUIET_CYCLES = 8
) (
    input  logic             sys_clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] bus_line,
    input  logic [WIDTH-1:0] mask,
    input  logic             clear,
    output logic             quiet_ok
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0] Q_MAX = QW'(QUIET_CYCLES);

    logic [WIDTH-1:0] prev_bus_q;
    logic [WIDTH-1:0] prev_bus_d;
    logic [QW-1:0]    quiet_cnt_q;
    logic [QW-1:0]    quiet_cnt_d;
    logic             quiet_s;

    // Quiet compare, saturating quiet counter and the look-ahead quiet flag.
    always_comb begin
        prev_bus_d  = bus_line;
        quiet_s     = (((bus_line ^ prev_bus_q) & mask) == {WIDTH{1'b0}});
        quiet_cnt_d = quiet_cnt_q;
        if (clear) begin
            quiet_cnt_d = {QW{1'b0}};
        end else if (!quiet_s) begin
            quiet_cnt_d = {QW{1'b0}};
        end else if (quiet_cnt_q != Q_MAX) begin
            quiet_cnt_d = quiet_cnt_q + QW'(1);
        end else begin
            quiet_cnt_d = quiet_cnt_q;
        end
        // Flags the edge at which the count becomes QUIET_CYCLES, so the
        // controller switches on that very edge. It deliberately ignores
        // clear: clear is derived from the controller's next state, which
        // itself depends on this flag.
        quiet_ok = quiet_s && (quiet_cnt_q >= (Q_MAX - QW'(1)));
    end

    // Bus history and quiet counter registers.
    always_ff @(posedge sys_clk) begin
        if (!n_reset) begin
            prev_bus_q  <= {WIDTH{1'b0}};
            quiet_cnt_q <= {QW{1'b0}};
        end else begin
            prev_bus_q  <= prev_bus_d;
            quiet_cnt_q <= quiet_cnt_d;
        end
    end

endmodule : mux_select_ctrl_quiet_detector

// File: rtl/mux_select_ctrl.sv
// -----------------------------------------------------------------------------
// mux_select_ctrl
// Sequences the per-bit output mux selects that switch bus lines between
// pass-through (0) and injected data (1). A command is switched in only after
// the targeted lines have been quiet for QUIET_CYCLES, held for a programmed
// number of cycles (0 = until abort), and released at the next quiet point.
//
// Ports:
//   sys_clk       in   system clock
//   n_reset       in   synchronous active-low reset
//   cmd_valid     in   command present
//   cmd_ready     out  controller idle and able to take a command
//   cmd_mask      in   WIDTH     lines to switch to the injected source
//   cmd_duration  in   DUR_BITS  hold cycles, 0 = hold until abort
//   abort         in   cancel a pending switch / end the hold early
//   bus_line      in   WIDTH     observed original bus
//   select_line   out  WIDTH     mux selects, 1 = injected source
//   busy          out  command in flight
//   done          out  one-cycle pulse: lines released after a command
//   timeout       out  one-cycle pulse: quiet wait ran out of time
// -----------------------------------------------------------------------------
module mux_select_ctrl
    import mux_select_ctrl_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int QUIET_CYCLES   = 8,
    parameter int DUR_BITS       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                sys_clk,
    input  logic                n_reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [WIDTH-1:0]    cmd_mask,
    input  logic [DUR_BITS-1:0] cmd_duration,
    input  logic                abort,
    input  logic [WIDTH-1:0]    bus_line,
    output logic [WIDTH-1:0]    select_line,
    output logic                busy,
    output logic                done,
    output logic                timeout
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] W_MAX  = WW'(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT_CYCLES - 1);

    state_e              state_q;
    state_e              state_d;
    logic [WIDTH-1:0]    mask_q;
    logic [WIDTH-1:0]    mask_d;
    logic [DUR_BITS-1:0] dur_q;
    logic [DUR_BITS-1:0] dur_d;
    logic [DUR_BITS-1:0] hold_cnt_q;
    logic [DUR_BITS-1:0] hold_cnt_d;
    logic [WW-1:0]       wait_cnt_q;
    logic [WW-1:0]       wait_cnt_d;
    logic [WIDTH-1:0]    select_q;
    logic [WIDTH-1:0]    select_d;
    logic                cmd_ready_q;
    logic                cmd_ready_d;
    logic                busy_q;
    logic                busy_d;
    logic                done_q;
    logic                done_d;
    logic                timeout_q;
    logic                timeout_d;

    logic                clear_s;
    logic                quiet_ok_s;
    logic                wait_expire_s;

    mux_select_ctrl_quiet_detector #(
        .WIDTH        (WIDTH),
        .QUIET_CYCLES (QUIET_CYCLES)
    ) u_quiet (
        .sys_clk  (sys_clk),
        .n_reset  (n_reset),
        .bus_line (bus_line),
        .mask     (mask_q),
        .clear    (clear_s),
        .quiet_ok (quiet_ok_s)
    );

    // Next-state, latched command, select and pulse generation.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        dur_d      = dur_q;
        hold_cnt_d = hold_cnt_q;
        select_d   = select_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        // The wait counter started at 0 on state entry, so this flags the
        // edge at which it would reach TIMEOUT_CYCLES.
        wait_expire_s = (wait_cnt_q == W_LAST);

        case (state_q)
            ST_IDLE: begin
                select_d = {WIDTH{1'b0}};
                // abort is ignored here, even alongside an accepted command.
                if (cmd_valid && cmd_ready_q) begin
                    mask_d = cmd_mask;
                    dur_d  = cmd_duration;
                    if (cmd_mask == {WIDTH{1'b0}}) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_QUIET;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_QUIET: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    select_d = {WIDTH{1'b0}};
                end else if (quiet_ok_s) begin
                    select_d   = mask_q;
                    hold_cnt_d = dur_q;
                    state_d    = ST_ACTIVE;
                end else if (wait_expire_s) begin
                    timeout_d = 1'b1;
                    select_d  = {WIDTH{1'b0}};
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_QUIET;
                end
            end

            ST_ACTIVE: begin
                select_d = mask_q;
                // Abort wins over a simultaneous expiry; both lead to release.
                if (abort) begin
                    state_d = ST_RELEASE_WAIT;
                end else if (dur_q != {DUR_BITS{1'b0}}) begin
                    // hold_cnt was loaded with dur_q on entry; leaving when it
                    // reads 1 keeps the lines switched for exactly dur_q cycles.
                    if (hold_cnt_q == DUR_BITS'(1)) begin
                        state_d = ST_RELEASE_WAIT;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                    if (hold_cnt_q != {DUR_BITS{1'b0}}) begin
                        hold_cnt_d = hold_cnt_q - DUR_BITS'(1);
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end

            ST_RELEASE_WAIT: begin
                select_d = mask_q;
                if (quiet_ok_s) begin
                    select_d = {WIDTH{1'b0}};
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (wait_expire_s) begin
                    // Lines are forced back even on a busy bus.
                    select_d  = {WIDTH{1'b0}};
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE_WAIT;
                end
            end

            default: begin
                select_d = {WIDTH{1'b0}};
                state_d  = ST_IDLE;
            end
        endcase

        cmd_ready_d = !is_busy_state(state_d);
        busy_d      = is_busy_state(state_d);
    end

    // State-entry detection and the bounded wait counter.
    always_comb begin
        clear_s    = (state_d != state_q);
        wait_cnt_d = wait_cnt_q;
        if (clear_s) begin
            wait_cnt_d = {WW{1'b0}};
        end else if (is_wait_state(state_q) && (wait_cnt_q != W_MAX)) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Controller registers; reset drops the selects immediately.
    always_ff @(posedge sys_clk) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= {WIDTH{1'b0}};
            dur_q       <= {DUR_BITS{1'b0}};
            hold_cnt_q  <= {DUR_BITS{1'b0}};
            wait_cnt_q  <= {WW{1'b0}};
            select_q    <= {WIDTH{1'b0}};
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            dur_q       <= dur_d;
            hold_cnt_q  <= hold_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            select_q    <= select_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign select_line = select_q;
    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule : mux_select_ctrl

// File: tb/tb_mux_select_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_select_ctrl
// Self-checking bench for mux_select_ctrl. Each command pushes its expected
// outcome (switch latency, switched length, select value, done/timeout
// latency and counts) onto a queue; the outcome observed on the DUT outputs
// is then popped against it. Latencies are counted in clock edges from the
// accepting edge.
// -----------------------------------------------------------------------------
module tb_mux_select_ctrl;

    localparam int QC = 8;
    localparam int TO = 1024;

    logic        sys_clk = 1'b0;
    logic        n_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_mask;
    logic [15:0] cmd_duration;
    logic        abort;
    logic [3:0]  bus_line;
    logic [3:0]  select_line;
    logic        busy;
    logic        done;
    logic        timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int sw;     // edges from accept to first switched sample, -1 none
        int hi;     // number of samples with selects asserted
        int val;    // select value while switched
        int dlat;   // edges from accept to done, -1 none
        int tlat;   // edges from accept to timeout, -1 none
        int dcnt;
        int tcnt;
    } exp_t;

    exp_t exp_q[$];

    mux_select_ctrl dut (
        .sys_clk      (sys_clk),
        .n_reset      (n_reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mask     (cmd_mask),
        .cmd_duration (cmd_duration),
        .abort        (abort),
        .bus_line     (bus_line),
        .select_line  (select_line),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Issue one command, drive bus activity / abort, observe until idle.
    task automatic run_cmd(input string tag, input logic [3:0] m,
                           input logic [15:0] d, input bit ab_acc,
                           input int abort_at, input logic [3:0] tog_mask,
                           input int tog_per, input exp_t e);
        int   sw, last, dlat, tlat, dc, tc, post, val, k;
        logic [3:0] bad;
        exp_t ex;
        for (int w = 0; w < 20 && !cmd_ready; w++) tick();
        check_val({tag, "/ready_in"}, int'(cmd_ready), 1);
        exp_q.push_back(e);
        cmd_valid    = 1'b1;
        cmd_mask     = m;
        cmd_duration = d;
        abort        = ab_acc;
        tick();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        sw = -1; last = -1; dlat = -1; tlat = -1; dc = 0; tc = 0;
        post = -1; val = 0; bad = 4'b0000; k = 0;
        while (k < 1200 && (post < 0 || k <= post + 2)) begin
            if (select_line != 4'b0000) begin
                if (sw < 0) begin
                    sw  = k;
                    val = int'(select_line);
                end
                last = k;
            end
            bad = bad | (select_line & ~m);
            if (done) begin
                dc++;
                dlat = k;
            end
            if (timeout) begin
                tc++;
                tlat = k;
            end
            if (!busy && post < 0) post = k;
            abort = (k == abort_at);
            if (tog_per != 0 && (k % tog_per) == 0) bus_line = bus_line ^ tog_mask;
            tick();
            k++;
        end
        abort = 1'b0;
        check_val({tag, "/returned_idle"}, int'(post >= 0), 1);
        check_val({tag, "/ready_out"}, int'(cmd_ready), 1);
        ex = exp_q.pop_front();
        check_val({tag, "/switch_lat"}, sw, ex.sw);
        check_val({tag, "/switch_len"}, (sw < 0) ? 0 : (last - sw + 1), ex.hi);
        check_val({tag, "/select_val"}, val, ex.val);
        check_val({tag, "/done_lat"}, dlat, ex.dlat);
        check_val({tag, "/timeout_lat"}, tlat, ex.tlat);
        check_val({tag, "/done_cnt"}, dc, ex.dcnt);
        check_val({tag, "/timeout_cnt"}, tc, ex.tcnt);
        check_val({tag, "/unmasked_sel"}, int'(bad), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_reset      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_mask     = 4'b0000;
        cmd_duration = 16'd0;
        abort        = 1'b0;
        bus_line     = 4'b0000;
        tick(); tick(); tick();
        check_val("rst/select", int'(select_line), 0);
        check_val("rst/ready", int'(cmd_ready), 0);
        check_val("rst/busy", int'(busy), 0);
        check_val("rst/done", int'(done), 0);
        check_val("rst/timeout", int'(timeout), 0);
        n_reset = 1'b1;
        tick();
        check_val("rel/ready", int'(cmd_ready), 1);
        check_val("rel/busy", int'(busy), 0);
        tick();

        // Static bus, timed hold.
        run_cmd("static", 4'b0101, 16'd5, 1'b0, -1, 4'b0000, 0,
                '{QC, 5 + QC, 5, QC + 5 + QC, -1, 1, 0});
        // Masked line keeps toggling: never quiet, times out.
        run_cmd("toggle", 4'b0001, 16'd5, 1'b0, -1, 4'b0001, 4,
                '{-1, 0, 0, -1, TO, 0, 1});
        // Activity on an unmasked line is ignored.
        run_cmd("unmasked", 4'b0001, 16'd3, 1'b0, -1, 4'b0100, 2,
                '{QC, 3 + QC, 1, QC + 3 + QC, -1, 1, 0});
        // Indefinite hold ended by abort.
        run_cmd("hold_abort", 4'b1000, 16'd0, 1'b0, 50, 4'b0000, 0,
                '{QC, 51 - QC + QC, 8, 51 + QC, -1, 1, 0});
        // Abort while waiting for quiet: back to idle, no pulses.
        run_cmd("wait_abort", 4'b0110, 16'd7, 1'b0, 3, 4'b0000, 0,
                '{-1, 0, 0, -1, -1, 0, 0});
        // Empty mask completes immediately.
        run_cmd("empty_mask", 4'b0000, 16'd9, 1'b0, -1, 4'b0000, 0,
                '{-1, 0, 0, 0, -1, 1, 0});
        // Shortest hold; abort at accept and during release are both ignored.
        run_cmd("dur1", 4'b1001, 16'd1, 1'b1, 12, 4'b0000, 0,
                '{QC, 1 + QC, 9, QC + 1 + QC, -1, 1, 0});

        // Reset while switched drops the selects at that edge.
        cmd_valid    = 1'b1;
        cmd_mask     = 4'b1111;
        cmd_duration = 16'd0;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check_val("mid/select_on", int'(select_line), 15);
        n_reset = 1'b0;
        tick();
        check_val("mid_rst/select", int'(select_line), 0);
        check_val("mid_rst/busy", int'(busy), 0);
        check_val("mid_rst/ready", int'(cmd_ready), 0);
        n_reset = 1'b1;
        tick();
        check_val("mid_rel/ready", int'(cmd_ready), 1);
        run_cmd("after_rst", 4'b0010, 16'd3, 1'b0, -1, 4'b0000, 0,
                '{QC, 3 + QC, 2, QC + 3 + QC, -1, 1, 0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_select_ctrl
